// File: rtl/vx_csr_mpm_file.sv
// vx_csr_mpm_file: per-core CSR file (fcsr, counters, mscratch) with RMW ops.
// Define CSR_MPM_EN to build the mhpmcounter/mhpmevent bank.
module vx_csr_mpm_file #(
    parameter int NUM_WARPS      = 4,
    parameter int NUM_THREADS    = 4,
    parameter int NUM_COUNTERS   = 4,
    parameter int COUNTER_WIDTH  = 44,
    parameter int NUM_EVENTS     = 8,
    parameter int EVENT_CNT_BITS = 4,
    parameter int NW_BITS        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int CS_BITS        = $clog2(NUM_THREADS) + 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [11:0]                          req_addr,
    input  logic [NW_BITS-1:0]                   req_wid,
    input  logic [1:0]                           req_op,
    input  logic [31:0]                          req_data,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [31:0]                          rsp_data,
    output logic [NW_BITS-1:0]                   rsp_wid,
    output logic                                 rsp_illegal,
    input  logic                                 busy,
    input  logic                                 commit_valid,
    input  logic [CS_BITS-1:0]                   commit_size,
    input  logic [NUM_EVENTS*EVENT_CNT_BITS-1:0] events,
    input  logic                                 fflags_valid,
    input  logic [NW_BITS-1:0]                   fflags_wid,
    input  logic [4:0]                           fflags,
    input  logic [NW_BITS-1:0]                   frm_wid,
    output logic [2:0]                           frm
);
    localparam int CW = COUNTER_WIDTH;
`ifdef CSR_MPM_EN
    localparam int EB = EVENT_CNT_BITS;
    localparam int SEL_BITS = $clog2(NUM_EVENTS + 1);
    localparam logic [31:0] INH_MASK =
        32'h5 | (((32'h1 << NUM_COUNTERS) - 32'h1) << 3);
    logic [CW-1:0]       hpm_q [NUM_COUNTERS];
    logic [CW-1:0]       hpm_d [NUM_COUNTERS];
    logic [SEL_BITS-1:0] sel_q [NUM_COUNTERS];
    logic [SEL_BITS-1:0] sel_d [NUM_COUNTERS];
`else
    localparam logic [31:0] INH_MASK = 32'h5;
    logic unused_events;
    assign unused_events = ^events;
`endif

    logic [7:0]         fcsr_q [NUM_WARPS];
    logic [7:0]         fcsr_d [NUM_WARPS];
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        inhibit_q, inhibit_d;
    logic [CW-1:0]      mcycle_q, mcycle_d;
    logic [CW-1:0]      minstret_q, minstret_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [NW_BITS-1:0] rsp_wid_q, rsp_wid_d;
    logic               rsp_illegal_q, rsp_illegal_d;

    logic        accept, known, ro, modify, illegal, wr_en;
    logic [7:0]  cur_fcsr;
    logic [31:0] old_val, new_val;

    assign req_ready   = !rsp_valid_q || rsp_ready;
    assign accept      = req_valid && req_ready;
    assign frm         = fcsr_q[frm_wid][7:5];
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_wid     = rsp_wid_q;
    assign rsp_illegal = rsp_illegal_q;

    // Read decode: old value, whether the address exists, and read-only flag.
    always_comb begin
        cur_fcsr = fcsr_q[req_wid];
        known    = 1'b1;
        ro       = 1'b0;
        old_val  = '0;
        case (req_addr)
            12'h001: old_val = {27'b0, cur_fcsr[4:0]};
            12'h002: old_val = {29'b0, cur_fcsr[7:5]};
            12'h003: old_val = {24'b0, cur_fcsr};
            12'h320: old_val = inhibit_q;
            12'h340: old_val = mscratch_q;
            12'hB00: old_val = mcycle_q[31:0];
            12'hB80: old_val = 32'(mcycle_q >> 32);
            12'hB02: old_val = minstret_q[31:0];
            12'hB82: old_val = 32'(minstret_q >> 32);
            12'hC00: begin old_val = mcycle_q[31:0]; ro = 1'b1; end
            12'hC80: begin old_val = 32'(mcycle_q >> 32); ro = 1'b1; end
            12'hC02: begin old_val = minstret_q[31:0]; ro = 1'b1; end
            12'hC82: begin old_val = 32'(minstret_q >> 32); ro = 1'b1; end
            12'hCC0: begin old_val = 32'(req_wid); ro = 1'b1; end
            12'hCC1: begin old_val = 32'(NUM_WARPS); ro = 1'b1; end
            default: known = 1'b0;
        endcase
        for (int i = 0; i < NUM_COUNTERS; i++) begin
`ifdef CSR_MPM_EN
            if (req_addr == 12'h323 + 12'(i)) begin
                known = 1'b1; old_val = 32'(sel_q[i]);
            end
            if (req_addr == 12'hB03 + 12'(i)) begin
                known = 1'b1; old_val = hpm_q[i][31:0];
            end
            if (req_addr == 12'hB83 + 12'(i)) begin
                known = 1'b1; old_val = 32'(hpm_q[i] >> 32);
            end
            if (req_addr == 12'hC03 + 12'(i)) begin
                known = 1'b1; ro = 1'b1; old_val = hpm_q[i][31:0];
            end
            if (req_addr == 12'hC83 + 12'(i)) begin
                known = 1'b1; ro = 1'b1; old_val = 32'(hpm_q[i] >> 32);
            end
`else
            // Bank absent: addresses stay legal, read 0, drop writes.
            if (req_addr == 12'h323 + 12'(i) || req_addr == 12'hB03 + 12'(i) ||
                req_addr == 12'hB83 + 12'(i) || req_addr == 12'hC03 + 12'(i) ||
                req_addr == 12'hC83 + 12'(i))
                known = 1'b1;
`endif
        end
    end

    assign modify  = (req_op == 2'b01) || (req_op[1] && (|req_data));
    assign illegal = !known || (ro && modify);
    assign wr_en   = accept && !illegal && modify;

    always_comb begin
        case (req_op)
            2'b01:   new_val = req_data;
            2'b10:   new_val = old_val | req_data;
            2'b11:   new_val = old_val & ~req_data;
            default: new_val = old_val;
        endcase
    end

    always_comb begin
        mscratch_d = mscratch_q;
        inhibit_d  = inhibit_q;
        mcycle_d   = inhibit_q[0] ? mcycle_q : mcycle_q + CW'(busy);
        minstret_d = (inhibit_q[2] || !commit_valid) ? minstret_q
                   : minstret_q + CW'(commit_size);
        for (int w = 0; w < NUM_WARPS; w++)
            fcsr_d[w] = fcsr_q[w];
        if (wr_en) begin
            case (req_addr)
                12'h001: fcsr_d[req_wid][4:0] = new_val[4:0];
                12'h002: fcsr_d[req_wid][7:5] = new_val[2:0];
                12'h003: fcsr_d[req_wid]      = new_val[7:0];
                12'h320: inhibit_d  = new_val & INH_MASK;
                12'h340: mscratch_d = new_val;
                12'hB00: mcycle_d   = {mcycle_q[CW-1:32], new_val};
                12'hB80: mcycle_d   = {new_val[CW-33:0], mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[CW-1:32], new_val};
                12'hB82: minstret_d = {new_val[CW-33:0], minstret_q[31:0]};
                default: ;
            endcase
        end
        // FPU flags are sticky and merge with a same-cycle CSR write.
        if (fflags_valid)
            fcsr_d[fflags_wid][4:0] = fcsr_d[fflags_wid][4:0] | fflags;
`ifdef CSR_MPM_EN
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            sel_d[i] = sel_q[i];
            hpm_d[i] = hpm_q[i];
            if (!inhibit_q[3+i]) begin
                for (int e = 0; e < NUM_EVENTS; e++)
                    if (sel_q[i] == SEL_BITS'(e + 1))
                        hpm_d[i] = hpm_q[i] + CW'(events[e*EB +: EB]);
            end
            if (wr_en && req_addr == 12'h323 + 12'(i))
                sel_d[i] = (new_val > 32'(NUM_EVENTS)) ? '0
                         : new_val[SEL_BITS-1:0];
            if (wr_en && req_addr == 12'hB03 + 12'(i))
                hpm_d[i] = {hpm_q[i][CW-1:32], new_val};
            if (wr_en && req_addr == 12'hB83 + 12'(i))
                hpm_d[i] = {new_val[CW-33:0], hpm_q[i][31:0]};
        end
`endif
    end

    always_comb begin
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_wid_d     = rsp_wid_q;
        rsp_illegal_d = rsp_illegal_q;
        if (accept) begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = illegal ? 32'h0 : old_val;
            rsp_wid_d     = req_wid;
            rsp_illegal_d = illegal;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++)
                fcsr_q[w] <= '0;
            mscratch_q    <= '0;
            inhibit_q     <= '0;
            mcycle_q      <= '0;
            minstret_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_wid_q     <= '0;
            rsp_illegal_q <= 1'b0;
`ifdef CSR_MPM_EN
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                hpm_q[i] <= '0;
                sel_q[i] <= '0;
            end
`endif
        end else begin
            for (int w = 0; w < NUM_WARPS; w++)
                fcsr_q[w] <= fcsr_d[w];
            mscratch_q    <= mscratch_d;
            inhibit_q     <= inhibit_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_wid_q     <= rsp_wid_d;
            rsp_illegal_q <= rsp_illegal_d;
`ifdef CSR_MPM_EN
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                hpm_q[i] <= hpm_d[i];
                sel_q[i] <= sel_d[i];
            end
`endif
        end
    end
endmodule

// File: tb/tb_vx_csr_mpm_file.sv
// tb_vx_csr_mpm_file: directed plus random stimulus against a CSR-level model.
// Follows CSR_MPM_EN the same way the design does.
module tb_vx_csr_mpm_file;
    localparam int NW = 4, NT = 4, NC = 4, CW = 44, NE = 8, EB = 4;
    localparam int NWB = 2, CSB = 3;
`ifdef CSR_MPM_EN
    localparam bit MPM = 1'b1;
`else
    localparam bit MPM = 1'b0;
`endif
    localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;
    localparam logic [31:0] INHM =
        32'h5 | (MPM ? (((32'h1 << NC) - 32'h1) << 3) : 32'h0);

    logic clk = 1'b0, reset = 1'b1;
    logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_illegal;
    logic [11:0] req_addr;
    logic [NWB-1:0] req_wid, rsp_wid, fflags_wid, frm_wid;
    logic [1:0] req_op;
    logic [31:0] req_data, rsp_data;
    logic busy, commit_valid, fflags_valid;
    logic [CSB-1:0] commit_size;
    logic [NE*EB-1:0] events;
    logic [4:0] fflags;
    logic [2:0] frm;

    vx_csr_mpm_file #(
        .NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_COUNTERS(NC),
        .COUNTER_WIDTH(CW), .NUM_EVENTS(NE), .EVENT_CNT_BITS(EB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wid(req_wid), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_wid(rsp_wid), .rsp_illegal(rsp_illegal),
        .busy(busy), .commit_valid(commit_valid), .commit_size(commit_size),
        .events(events), .fflags_valid(fflags_valid), .fflags_wid(fflags_wid),
        .fflags(fflags), .frm_wid(frm_wid), .frm(frm)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural state of the CSR file, current and next.
    logic [63:0] m_cyc, m_ins, n_cyc, n_ins;
    logic [63:0] m_cnt [NC], n_cnt [NC];
    int unsigned m_sel [NC], n_sel [NC];
    logic [31:0] m_inh, m_scr, n_inh, n_scr;
    logic [7:0]  m_fcsr [NW], n_fcsr [NW];
    bit m_rv, m_ri;
    logic [31:0] m_rd;
    int m_rw;

    function automatic void model_reset();
        m_cyc = 0; m_ins = 0; m_inh = 0; m_scr = 0;
        for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_sel[i] = 0; end
        for (int w = 0; w < NW; w++) m_fcsr[w] = 0;
        m_rv = 0; m_ri = 0; m_rd = 0; m_rw = 0;
    endfunction

    function automatic void csr_read(input logic [11:0] a, input int w,
                                     output bit ok, output bit ro,
                                     output logic [31:0] v);
        logic [63:0] c;
        int k;
        ok = 1; ro = 0; v = 0; c = 0;
        if (a == 12'h001) v = 32'(m_fcsr[w][4:0]);
        else if (a == 12'h002) v = 32'(m_fcsr[w][7:5]);
        else if (a == 12'h003) v = 32'(m_fcsr[w]);
        else if (a == 12'h320) v = m_inh;
        else if (a >= 12'h323 && int'(a) < 'h323 + NC)
            v = MPM ? m_sel[int'(a) - 'h323] : 0;
        else if (a == 12'h340) v = m_scr;
        else if ((a[11:8] == 4'hB || a[11:8] == 4'hC) && a[6:5] == 2'b00) begin
            k = int'(a[4:0]);
            ro = (a[11:8] == 4'hC);
            if (k == 0) c = m_cyc;
            else if (k == 2) c = m_ins;
            else if (k >= 3 && k < 3 + NC) begin
                c = MPM ? m_cnt[k-3] : 0;
                if (!MPM) ro = 0;
            end else ok = 0;
            v = a[7] ? c[63:32] : c[31:0];
        end
        else if (a == 12'hCC0) begin v = w; ro = 1; end
        else if (a == 12'hCC1) begin v = NW; ro = 1; end
        else ok = 0;
    endfunction

    function automatic logic [63:0] put(input logic [63:0] v, input bit hi,
                                        input logic [31:0] d);
        if (hi) v[63:32] = d; else v[31:0] = d;
        return v & CMASK;
    endfunction

    function automatic void csr_write(input logic [11:0] a, input int w,
                                      input logic [31:0] nv);
        int k;
        if (a == 12'h001) n_fcsr[w][4:0] = nv[4:0];
        else if (a == 12'h002) n_fcsr[w][7:5] = nv[2:0];
        else if (a == 12'h003) n_fcsr[w] = nv[7:0];
        else if (a == 12'h320) n_inh = nv & INHM;
        else if (a >= 12'h323 && int'(a) < 'h323 + NC) begin
            if (MPM) n_sel[int'(a) - 'h323] = (nv > NE) ? 0 : nv;
        end
        else if (a == 12'h340) n_scr = nv;
        else if (a[11:8] == 4'hB && a[6:5] == 2'b00) begin
            k = int'(a[4:0]);
            if (k == 0) n_cyc = put(m_cyc, a[7], nv);
            else if (k == 2) n_ins = put(m_ins, a[7], nv);
            else if (k >= 3 && k < 3 + NC && MPM)
                n_cnt[k-3] = put(m_cnt[k-3], a[7], nv);
        end
    endfunction

    // One clock: predict from current inputs, clock, then compare.
    task automatic step();
        bit exp_ready, acc, ok, ro, modify, illegal;
        logic [31:0] old, nv;
        #1;
        exp_ready = !m_rv || rsp_ready;
        check("req_ready", req_ready, exp_ready);
        check("frm", frm, m_fcsr[frm_wid][7:5]);
        n_cyc = (m_cyc + (m_inh[0] ? 0 : busy)) & CMASK;
        n_ins = (m_ins + ((m_inh[2] || !commit_valid) ? 0 : commit_size)) & CMASK;
        n_inh = m_inh; n_scr = m_scr; n_fcsr = m_fcsr;
        for (int i = 0; i < NC; i++) begin
            n_cnt[i] = m_cnt[i]; n_sel[i] = m_sel[i];
            if (MPM && !m_inh[3+i] && m_sel[i] != 0)
                n_cnt[i] = (m_cnt[i] + ((events >> ((m_sel[i] - 1) * EB)) & 32'hF))
                         & CMASK;
        end
        acc = req_valid && exp_ready;
        illegal = 0; old = 0;
        if (acc) begin
            csr_read(req_addr, int'(req_wid), ok, ro, old);
            modify = (req_op == 2'd1) || (req_op >= 2'd2 && req_data != 0);
            illegal = !ok || (ro && modify);
            case (req_op)
                2'd1: nv = req_data;
                2'd2: nv = old | req_data;
                2'd3: nv = old & ~req_data;
                default: nv = old;
            endcase
            if (!illegal && modify) csr_write(req_addr, int'(req_wid), nv);
        end
        if (fflags_valid) n_fcsr[fflags_wid][4:0] = n_fcsr[fflags_wid][4:0] | fflags;
        if (acc) begin
            m_rv = 1; m_rd = illegal ? 0 : old; m_rw = int'(req_wid); m_ri = illegal;
        end else if (rsp_ready) m_rv = 0;
        @(posedge clk); #1;
        m_cyc = n_cyc; m_ins = n_ins; m_inh = n_inh; m_scr = n_scr;
        m_fcsr = n_fcsr; m_cnt = n_cnt; m_sel = n_sel;
        check("rsp_valid", rsp_valid, m_rv);
        if (m_rv) begin
            check("rsp_data", rsp_data, m_rd);
            check("rsp_wid", rsp_wid, m_rw);
            check("rsp_illegal", rsp_illegal, m_ri);
        end
    endtask

    task automatic idle();
        req_valid = 0; req_addr = 0; req_wid = 0; req_op = 0; req_data = 0;
        rsp_ready = 1; busy = 0; commit_valid = 0; commit_size = 0;
        events = 0; fflags_valid = 0; fflags_wid = 0; fflags = 0; frm_wid = 0;
    endtask

    task automatic do_req(input logic [11:0] a, input int w, input int op,
                          input logic [31:0] d);
        req_valid = 1; req_addr = a; req_wid = NWB'(w);
        req_op = 2'(op); req_data = d;
        step();
        req_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_wid", rsp_wid, 0);
        check("rst_rsp_illegal", rsp_illegal, 0);
        check("rst_req_ready", req_ready, 1);
        reset = 0;
    endtask

    logic [11:0] alist [26] = '{
        12'h001, 12'h002, 12'h003, 12'h320, 12'h323, 12'h324, 12'h325,
        12'h326, 12'h327, 12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
        12'hB03, 12'hB84, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC03,
        12'hC86, 12'hCC0, 12'hCC1, 12'hB01, 12'h300
    };

    initial begin
        idle();
        do_reset();

        // Cycle counter visible after 10 busy cycles, 1-cycle latency.
        busy = 1;
        repeat (10) step();
        do_req(12'hB00, 0, 0, 0);
        check("mcycle10_valid", rsp_valid, 1);
        check("mcycle10", rsp_data, 10);
        check("mcycle10_illegal", rsp_illegal, 0);
        busy = 0;

        // Event-driven counter and event-select WARL.
        do_req(12'h323, 0, 1, 3);
        events = 32'(2) << (2 * EB);
        repeat (5) step();
        events = 0;
        do_req(12'hB03, 0, 0, 0);
        check("hpm3_count", rsp_data, MPM ? 10 : 0);
        do_req(12'h323, 0, 1, 50);
        do_req(12'h323, 0, 0, 0);
        check("evsel_warl", rsp_data, 0);

        // fflags set colliding with an FPU flag update on the same warp.
        fflags_valid = 1; fflags_wid = 1; fflags = 5'h01;
        do_req(12'h001, 1, 2, 32'h4);
        fflags_valid = 0;
        do_req(12'h001, 1, 0, 0);
        check("fflags_w1", rsp_data, 5);
        do_req(12'h001, 0, 0, 0);
        check("fflags_w0", rsp_data, 0);

        // Read-only shadow: write illegal, zero-mask set legal.
        do_req(12'hC00, 0, 1, 32'h1234);
        check("ro_write_illegal", rsp_illegal, 1);
        check("ro_write_data", rsp_data, 0);
        do_req(12'hC00, 0, 2, 0);
        check("ro_set0_legal", rsp_illegal, 0);

        // Backpressure: three stalled cycles, then accept on release.
        do_req(12'h340, 2, 1, 32'hA5A5_0001);
        rsp_ready = 0; req_valid = 1; req_addr = 12'h340; req_op = 0;
        repeat (3) begin
            step();
            check("stall_ready", req_ready, 0);
        end
        rsp_ready = 1;
        step();
        check("release_data", rsp_data, 32'hA5A5_0001);
        req_valid = 0;
        step();

        // Counter wrap at COUNTER_WIDTH.
        do_req(12'hB80, 0, 1, 32'hFFF);
        do_req(12'hB00, 0, 1, 32'hFFFF_FFFF);
        busy = 1; step(); busy = 0;
        do_req(12'hB00, 0, 0, 0);
        check("wrap_lo", rsp_data, 0);
        do_req(12'hB80, 0, 0, 0);
        check("wrap_hi", rsp_data, 0);

        // Reset while a response is stalled discards it.
        rsp_ready = 0;
        do_req(12'h340, 3, 0, 0);
        #2 reset = 1;
        #1 check("midrst_rsp_valid", rsp_valid, 0);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            req_valid = ($urandom_range(0, 9) < 7);
            req_addr = ($urandom_range(0, 15) == 0) ? 12'($urandom)
                     : alist[$urandom_range(0, 25)];
            req_wid = NWB'($urandom);
            req_op = 2'($urandom);
            case ($urandom_range(0, 3))
                0: req_data = 0;
                1: req_data = $urandom_range(0, 12);
                default: req_data = $urandom;
            endcase
            rsp_ready = ($urandom_range(0, 3) != 0);
            busy = 1'($urandom);
            commit_valid = 1'($urandom);
            commit_size = CSB'($urandom_range(0, NT));
            events = $urandom;
            fflags_valid = ($urandom_range(0, 3) == 0);
            fflags_wid = NWB'($urandom);
            fflags = 5'($urandom);
            frm_wid = NWB'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
